// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss-fill controller fetching one block as sequential word reads

module cache_fill_dffe #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

module cache_fill_fsm #(
    parameter int ADDR_W     = 16,
    parameter int WORDS      = 8,
    parameter int WORD_BYTES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [2:0]        fill_word_index,
    output logic [ADDR_W-1:0] fill_address,
    output logic              write_tag_array
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(WORDS - 1);
    localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'(WORDS * WORD_BYTES - 1);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]  recv_cnt_q, recv_cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              issue_en, recv_en, base_en;
    logic [ADDR_W-1:0] issue_off, recv_off;

    cache_fill_dffe #(.W(CNT_W)) u_issue_cnt (
        .clk (clk),
        .rst (rst),
        .en  (issue_en),
        .d   (issue_cnt_d),
        .q   (issue_cnt_q)
    );

    cache_fill_dffe #(.W(CNT_W)) u_recv_cnt (
        .clk (clk),
        .rst (rst),
        .en  (recv_en),
        .d   (recv_cnt_d),
        .q   (recv_cnt_q)
    );

    cache_fill_dffe #(.W(ADDR_W)) u_base (
        .clk (clk),
        .rst (rst),
        .en  (base_en),
        .d   (base_d),
        .q   (base_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Word offsets stay inside the block, so adding to the aligned base never carries out of it.
    assign issue_off = ADDR_W'(issue_cnt_q) * ADDR_W'(WORD_BYTES);
    assign recv_off  = ADDR_W'(recv_cnt_q) * ADDR_W'(WORD_BYTES);
    assign base_d    = miss_address & BLOCK_MASK;

    always_comb begin
        state_d          = state_q;
        issue_en         = 1'b0;
        issue_cnt_d      = issue_cnt_q;
        recv_en          = 1'b0;
        recv_cnt_d       = recv_cnt_q;
        base_en          = 1'b0;
        fsm_busy         = 1'b0;
        mem_read_en      = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        fill_word_index  = '0;
        fill_address     = '0;
        write_tag_array  = 1'b0;

        case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    state_d     = FILL;
                    issue_en    = 1'b1;
                    issue_cnt_d = '0;
                    recv_en     = 1'b1;
                    recv_cnt_d  = '0;
                    base_en     = 1'b1;
                end
            end
            FILL: begin
                fsm_busy       = 1'b1;
                mem_read_en    = (issue_cnt_q < WORDS_C);
                memory_address = base_q + issue_off;
                if (mem_read_en) begin
                    issue_en    = 1'b1;
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end

                // Returns may overlap issues; the receive side is tracked independently.
                write_data_array = memory_data_valid;
                fill_word_index  = recv_cnt_q[2:0];
                fill_address     = base_q + recv_off;
                if (memory_data_valid) begin
                    recv_en    = 1'b1;
                    recv_cnt_d = recv_cnt_q + 1'b1;
                    if (recv_cnt_q == LAST_C) begin
                        write_tag_array = 1'b1;
                        state_d         = IDLE;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - directed vector bench for cache_fill_fsm

module tb_cache_fill_fsm;

    logic        clk;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  fill_word_index;
    logic [15:0] fill_address;
    logic        write_tag_array;

    int checks = 0;
    int errors = 0;

    cache_fill_fsm #(
        .ADDR_W     (16),
        .WORDS      (8),
        .WORD_BYTES (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .mem_read_en       (mem_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_word_index   (fill_word_index),
        .fill_address      (fill_address),
        .write_tag_array   (write_tag_array)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        miss;
        logic [15:0] addr;
        logic        valid;
        logic        busy;
        logic        rd;
        logic [15:0] maddr;
        logic        wr;
        logic [2:0]  idx;
        logic [15:0] faddr;
        logic        tag;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic r, input logic m, input logic [15:0] a,
                                    input logic v, input logic b, input logic rd,
                                    input logic [15:0] ma, input logic wr, input logic [2:0] ix,
                                    input logic [15:0] fa, input logic tg);
        vec_t t;
        t.rst = r; t.miss = m; t.addr = a; t.valid = v;
        t.busy = b; t.rd = rd; t.maddr = ma; t.wr = wr;
        t.idx = ix; t.faddr = fa; t.tag = tg;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Addresses/index are only compared when the matching strobe is expected, or when idle (all zero).
    task automatic check_outs(input string nm, input logic b, input logic rd, input logic [15:0] ma,
                              input logic wr, input logic [2:0] ix, input logic [15:0] fa,
                              input logic tg);
        chk({nm, " busy"}, 32'(fsm_busy), 32'(b));
        chk({nm, " rd"}, 32'(mem_read_en), 32'(rd));
        if (rd || !b) chk({nm, " maddr"}, 32'(memory_address), 32'(ma));
        chk({nm, " wr"}, 32'(write_data_array), 32'(wr));
        if (wr || !b) begin
            chk({nm, " idx"}, 32'(fill_word_index), 32'(ix));
            chk({nm, " faddr"}, 32'(fill_address), 32'(fa));
        end
        chk({nm, " tag"}, 32'(write_tag_array), 32'(tg));
    endtask

    task automatic check_idle(input string nm);
        check_outs(nm, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);
    endtask

    task automatic drive(input logic r, input logic m, input logic [15:0] a, input logic v);
        rst = r;
        miss_detected = m;
        miss_address = a;
        memory_data_valid = v;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Full fill with fixed memory latency lat: issues cycles 1-8, data cycles 1+lat..8+lat.
    task automatic run_fill(input logic [15:0] a, input int lat, input logic [15:0] exp_base,
                            input string nm);
        for (int c = 0; c <= 9 + lat; c++) begin
            logic v, b, rd, tg;
            logic [15:0] ma, fa;
            logic [2:0] ix;
            v  = (c >= 1 + lat) && (c <= 8 + lat);
            b  = (c >= 1) && (c <= 8 + lat);
            rd = (c >= 1) && (c <= 8);
            ma = exp_base + 16'(2 * (c - 1));
            ix = 3'(c - 1 - lat);
            fa = exp_base + 16'(2 * (c - 1 - lat));
            tg = (c == 8 + lat);
            drive(1'b0, c == 0, a, v);
            @(negedge clk);
            if (!b) check_idle($sformatf("%s c%0d", nm, c));
            else check_outs($sformatf("%s c%0d", nm, c), b, rd, ma, v, ix, fa, tg);
            next_cycle();
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 16'h0, 1'b0);
        next_cycle();

        // Reset with miss held, stale valid after reset, then miss 0x1236 with 4-cycle memory.
        add_vec(1, 1, 16'h1236, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0);
        add_vec(1, 1, 16'h1236, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0);
        add_vec(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0);
        add_vec(0, 1, 16'h1236, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0);
        add_vec(0, 0, 16'h0000, 0, 1, 1, 16'h1230, 0, 0, 16'h0000, 0);
        add_vec(0, 0, 16'h0000, 0, 1, 1, 16'h1232, 0, 0, 16'h0000, 0);
        add_vec(0, 0, 16'h0000, 0, 1, 1, 16'h1234, 0, 0, 16'h0000, 0);
        add_vec(0, 0, 16'h0000, 0, 1, 1, 16'h1236, 0, 0, 16'h0000, 0);
        add_vec(0, 0, 16'h0000, 1, 1, 1, 16'h1238, 1, 0, 16'h1230, 0);
        add_vec(0, 0, 16'h0000, 1, 1, 1, 16'h123A, 1, 1, 16'h1232, 0);
        add_vec(0, 0, 16'h0000, 1, 1, 1, 16'h123C, 1, 2, 16'h1234, 0);
        add_vec(0, 0, 16'h0000, 1, 1, 1, 16'h123E, 1, 3, 16'h1236, 0);
        add_vec(0, 0, 16'h0000, 1, 1, 0, 16'h0000, 1, 4, 16'h1238, 0);
        add_vec(0, 0, 16'h0000, 1, 1, 0, 16'h0000, 1, 5, 16'h123A, 0);
        add_vec(0, 0, 16'h0000, 1, 1, 0, 16'h0000, 1, 6, 16'h123C, 0);
        add_vec(0, 0, 16'h0000, 1, 1, 0, 16'h0000, 1, 7, 16'h123E, 1);
        add_vec(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].miss, vecs[i].addr, vecs[i].valid);
            @(negedge clk);
            check_outs($sformatf("vec%0d", i), vecs[i].busy, vecs[i].rd, vecs[i].maddr,
                       vecs[i].wr, vecs[i].idx, vecs[i].faddr, vecs[i].tag);
            next_cycle();
        end

        // Irregular return gaps: miss 0x2A5C, base 0x2A50.
        begin
            int vc[8] = '{3, 4, 7, 8, 9, 12, 15, 16};
            int n = 0;
            for (int c = 0; c <= 17; c++) begin
                logic v;
                v = (n < 8) && (c == vc[n]);
                drive(1'b0, c == 0, 16'h2A5C, v);
                @(negedge clk);
                if (c == 0 || c == 17) begin
                    check_idle($sformatf("gap c%0d", c));
                end else begin
                    check_outs($sformatf("gap c%0d", c), 1'b1, c <= 8,
                               16'h2A50 + 16'(2 * (c - 1)), v, 3'(n),
                               16'h2A50 + 16'(2 * n), v && (n == 7));
                end
                if (v) n++;
                next_cycle();
            end
            chk("gap write count", 32'(n), 32'd8);
        end

        // Second miss held during a fill, then reset in cycle 6 of the new fill.
        for (int c = 0; c <= 22; c++) begin
            logic m, v, r;
            m = (c == 0) || (c >= 3 && c <= 13);
            v = (c >= 5 && c <= 12) || (c >= 18);
            r = (c == 19);
            drive(r, m, (c == 0) ? 16'h1236 : 16'h4000, v);
            @(negedge clk);
            if (c >= 1 && c <= 8)
                check_outs($sformatf("ovl c%0d", c), 1, 1, 16'h1230 + 16'(2 * (c - 1)),
                           v, 3'(c - 5), 16'h1230 + 16'(2 * (c - 5)), 0);
            else if (c == 12)
                check_outs("ovl c12", 1, 0, 16'h0, 1, 3'd7, 16'h123E, 1);
            else if (c == 13 || c >= 20)
                check_idle($sformatf("ovl c%0d", c));
            else if (c == 14)
                check_outs("ovl c14", 1, 1, 16'h4000, 0, 3'd0, 16'h0, 0);
            else if (c == 18)
                check_outs("ovl c18", 1, 1, 16'h4008, 1, 3'd0, 16'h4000, 0);
            else if (c == 19)
                check_outs("ovl c19", 1, 1, 16'h400A, 1, 3'd1, 16'h4002, 0);
            next_cycle();
        end
        drive(1'b0, 1'b0, 16'h0, 1'b0);
        next_cycle();

        run_fill(16'hFFF8, 4, 16'hFFF0, "top");
        run_fill(16'h8ABF, 1, 16'h8AB0, "lat1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
